// File: rtl/ifd3_capture.sv
// Three-channel input capture: per-pin synchroniser and debouncer feeding a
// single-entry change-event register with valid/ack handshake and sticky overflow.
module ifd3_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic [2:0] CHG,
  output logic       EVT_VALID,
  output logic [2:0] EVT_DATA,
  input  logic       EVT_ACK,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam int unsigned     CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      PEND    = 1'b1;

  logic [2:0]    sync_q [SYNC_STAGES];
  logic [2:0]    sync_d [SYNC_STAGES];
  logic [2:0]    lvl_q, lvl_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    chg_q, chg_d;
  logic [0:0]    state_q, state_d;
  logic [2:0]    evt_data_q, evt_data_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    sync_s;

  always_comb begin
    sync_d[0] = {D2, D1, D0};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Counter restarts whenever the synchronised value returns to the stable level.
  always_comb begin
    lvl_d = lvl_q;
    chg_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = sync_s[i];
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // CHG is registered alongside Q, so lvl_q already holds the new snapshot here.
  always_comb begin
    state_d    = state_q;
    evt_data_d = evt_data_q;
    ovf_d      = ovf_q;
    if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
    if (state_q == IDLE) begin
      if (chg_q != '0) begin
        state_d    = PEND;
        evt_data_d = lvl_q;
      end
    end else begin
      if (EVT_ACK) begin
        if (chg_q != '0) begin
          evt_data_d = lvl_q;
        end else begin
          state_d = IDLE;
        end
      end else if (chg_q != '0) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      lvl_q      <= '0;
      chg_q      <= '0;
      state_q    <= IDLE;
      evt_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lvl_q      <= lvl_d;
      chg_q      <= chg_d;
      state_q    <= state_d;
      evt_data_q <= evt_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Q0        = lvl_q[0];
  assign Q1        = lvl_q[1];
  assign Q2        = lvl_q[2];
  assign CHG       = chg_q;
  assign EVT_VALID = (state_q == PEND);
  assign EVT_DATA  = evt_data_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_ifd3_capture.sv
// Directed bench for ifd3_capture: expected change pulses are queued as pins are
// driven and checked by a monitor; latency, handshake and overflow checked inline.
module tb_ifd3_capture;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       D0 = 1'b0, D1 = 1'b0, D2 = 1'b0;
  logic       Q0, Q1, Q2;
  logic [2:0] CHG;
  logic       EVT_VALID;
  logic [2:0] EVT_DATA;
  logic       EVT_ACK = 1'b0;
  logic       OVF;
  logic       OVF_CLR = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] exp_chg_q [$];
  logic [2:0] exp_lvl_q [$];

  ifd3_capture #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .CK(CK), .RST(RST), .D0(D0), .D1(D1), .D2(D2),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .CHG(CHG),
    .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA), .EVT_ACK(EVT_ACK),
    .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CK);
  endtask

  task automatic drive(input logic [2:0] d, input logic [2:0] exp_chg);
    {D2, D1, D0} = d;
    if (exp_chg != '0) begin
      exp_chg_q.push_back(exp_chg);
      exp_lvl_q.push_back(d);
    end
  endtask

  // Every CHG pulse must match the oldest queued change, in order.
  always @(negedge CK) begin
    if (!RST && CHG != 3'b000) begin
      if (exp_chg_q.size() == 0) begin
        chk("unexpected_chg", CHG, 3'b000);
      end else begin
        chk("sb_chg", CHG, exp_chg_q.pop_front());
        chk("sb_q", {Q2, Q1, Q0}, exp_lvl_q.pop_front());
      end
    end
  end

  initial begin
    step(2);
    RST = 1'b0;
    step(1);
    chk("rst_q", {Q2, Q1, Q0}, 3'b000);
    chk("rst_chg", CHG, 3'b000);
    chk("rst_valid", {2'b0, EVT_VALID}, 3'b000);
    chk("rst_data", EVT_DATA, 3'b000);
    chk("rst_ovf", {2'b0, OVF}, 3'b000);

    // Single channel latency
    drive(3'b001, 3'b001);
    step(5);
    chk("lat_q_before", {Q2, Q1, Q0}, 3'b000);
    step(1);
    chk("lat_q", {Q2, Q1, Q0}, 3'b001);
    chk("lat_chg", CHG, 3'b001);
    chk("lat_valid_pre", {2'b0, EVT_VALID}, 3'b000);
    step(1);
    chk("lat_valid", {2'b0, EVT_VALID}, 3'b001);
    chk("lat_data", EVT_DATA, 3'b001);
    chk("lat_chg_one", CHG, 3'b000);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    chk("ack_valid", {2'b0, EVT_VALID}, 3'b000);

    // Glitch of three cycles on D1
    drive(3'b011, 3'b000);
    step(3);
    drive(3'b001, 3'b000);
    step(10);
    chk("glitch_q", {Q2, Q1, Q0}, 3'b001);
    chk("glitch_valid", {2'b0, EVT_VALID}, 3'b000);

    // Simultaneous change on D0 and D2
    drive(3'b000, 3'b001);
    step(7);
    chk("d0_fall_data", EVT_DATA, 3'b000);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    drive(3'b101, 3'b101);
    step(6);
    chk("sim_chg", CHG, 3'b101);
    step(1);
    chk("sim_valid", {2'b0, EVT_VALID}, 3'b001);
    chk("sim_data", EVT_DATA, 3'b101);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    chk("sim_ack_valid", {2'b0, EVT_VALID}, 3'b000);

    // Overflow: keep first snapshot, set beats clear
    drive(3'b100, 3'b001);
    step(7);
    chk("ovf_first_data", EVT_DATA, 3'b100);
    drive(3'b000, 3'b100);
    step(7);
    chk("ovf_set", {2'b0, OVF}, 3'b001);
    chk("ovf_keep_data", EVT_DATA, 3'b100);
    chk("ovf_valid", {2'b0, EVT_VALID}, 3'b001);
    drive(3'b001, 3'b001);
    step(6);
    OVF_CLR = 1'b1;
    step(1);
    OVF_CLR = 1'b0;
    chk("ovf_set_wins", {2'b0, OVF}, 3'b001);
    chk("ovf_keep_data2", EVT_DATA, 3'b100);
    OVF_CLR = 1'b1;
    step(1);
    OVF_CLR = 1'b0;
    chk("ovf_clr", {2'b0, OVF}, 3'b000);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    chk("ovf_ack_valid", {2'b0, EVT_VALID}, 3'b000);

    // ACK coinciding with a new change
    drive(3'b000, 3'b001);
    step(7);
    chk("coin_first", EVT_DATA, 3'b000);
    drive(3'b010, 3'b010);
    step(6);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    chk("coin_valid", {2'b0, EVT_VALID}, 3'b001);
    chk("coin_data", EVT_DATA, 3'b010);
    chk("coin_ovf", {2'b0, OVF}, 3'b000);
    EVT_ACK = 1'b1;
    step(1);
    EVT_ACK = 1'b0;
    chk("coin_idle", {2'b0, EVT_VALID}, 3'b000);

    // Asynchronous reset mid-debounce with an event pending
    drive(3'b110, 3'b100);
    step(7);
    chk("pre_rst_valid", {2'b0, EVT_VALID}, 3'b001);
    {D2, D1, D0} = 3'b111;
    step(3);
    #2 RST = 1'b1;
    #1;
    chk("arst_q", {Q2, Q1, Q0}, 3'b000);
    chk("arst_chg", CHG, 3'b000);
    chk("arst_valid", {2'b0, EVT_VALID}, 3'b000);
    chk("arst_data", EVT_DATA, 3'b000);
    chk("arst_ovf", {2'b0, OVF}, 3'b000);
    step(1);
    RST = 1'b0;
    exp_chg_q.push_back(3'b111);
    exp_lvl_q.push_back(3'b111);
    step(5);
    chk("post_rst_q_before", {Q2, Q1, Q0}, 3'b000);
    step(1);
    chk("post_rst_q", {Q2, Q1, Q0}, 3'b111);
    chk("post_rst_chg", CHG, 3'b111);
    step(1);
    chk("post_rst_valid", {2'b0, EVT_VALID}, 3'b001);
    chk("post_rst_data", EVT_DATA, 3'b111);
    step(2);
    chk("sb_drained", 3'(exp_chg_q.size()), 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
